regfile_seq_ctrl: RTL and testbench

- Sequencer that owns the register file's single read/write control port (rd_reg, wr_reg, wr_fromreg, wr_fromimm, din_reg).
- When idle, it passes the core's register accesses straight through.
- On exception, interrupt or exception-return requests, it takes the port and runs a fixed multi-cycle sequence of special-register moves: PC/ELR/CPSR/SPSR/ESR/vector pointers.
- Sits between the core control unit and the register file.

---
 rtl/regfile_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl.sv
// Register-file port sequencer: passes core accesses through when idle and
// runs fixed special-register move sequences for exception entry, IRQ entry and ERET.
module regfile_seq_ctrl #(
  parameter int          SPSR_COUNT   = 6,
  parameter logic [63:0] IRQ_SYNDROME = 64'h0000_0000_0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  core_rd_reg,
  input  logic [5:0]  core_wr_reg,
  input  logic        core_wr_fromreg,
  input  logic        core_wr_fromimm,
  input  logic [63:0] core_din,
  input  logic        exc_req,
  input  logic [63:0] exc_syndrome,
  input  logic        irq_req,
  input  logic        eret_req,
  input  logic [2:0]  cur_mode,
  input  logic [11:0] new_cpsr,
  output logic [5:0]  rd_reg,
  output logic [5:0]  wr_reg,
  output logic        wr_fromreg,
  output logic        wr_fromimm,
  output logic [63:0] din_reg,
  output logic        busy,
  output logic        done,
  output logic        seq_err
);

  localparam logic [5:0] REG_PC   = 6'd32;
  localparam logic [5:0] REG_ESR  = 6'd33;
  localparam logic [5:0] REG_ELR  = 6'd34;
  localparam logic [5:0] REG_CPSR = 6'd35;
  localparam logic [5:0] REG_SPSR = 6'd36;
  localparam logic [5:0] REG_IVP  = 6'd42;
  localparam logic [5:0] REG_EVP  = 6'd43;

  typedef enum logic [2:0] {
    IDLE, E_PC, E_PSR, E_SYN, E_CPSR, E_VEC, R_PC, R_PSR
  } state_t;

  state_t      state;
  logic [2:0]  mode_q;
  logic [11:0] cpsr_q;
  logic [63:0] syn_q;
  logic        vec_irq_q;
  logic        irq_pending;

  logic irq_any;
  logic mode_bad;
  logic [5:0] spsr_id;

  assign irq_any  = irq_req | irq_pending;
  assign mode_bad = (32'(cur_mode) >= 32'(SPSR_COUNT));
  assign spsr_id  = REG_SPSR + {3'b000, mode_q};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= '0;
      cpsr_q      <= '0;
      syn_q       <= '0;
      vec_irq_q   <= 1'b0;
      irq_pending <= 1'b0;
      done        <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      done    <= (state == E_VEC) || (state == R_PSR);
      seq_err <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_req) begin
            // a coincident irq is deferred, a coincident eret is dropped
            if (irq_req)  irq_pending <= 1'b1;
            if (eret_req) seq_err     <= 1'b1;
            if (mode_bad) begin
              seq_err <= 1'b1;
            end else begin
              mode_q    <= cur_mode;
              cpsr_q    <= new_cpsr;
              syn_q     <= exc_syndrome;
              vec_irq_q <= 1'b0;
              state     <= E_PC;
            end
          end else if (irq_any) begin
            irq_pending <= 1'b0;
            if (eret_req) seq_err <= 1'b1;
            if (mode_bad) begin
              seq_err <= 1'b1;
            end else begin
              mode_q    <= cur_mode;
              cpsr_q    <= new_cpsr;
              syn_q     <= IRQ_SYNDROME;
              vec_irq_q <= 1'b1;
              state     <= E_PC;
            end
          end else if (eret_req) begin
            if (mode_bad) begin
              seq_err <= 1'b1;
            end else begin
              mode_q <= cur_mode;
              state  <= R_PC;
            end
          end
        end
        default: begin
          if (irq_req) irq_pending <= 1'b1;
          if (exc_req || eret_req) seq_err <= 1'b1;
          case (state)
            E_PC:    state <= E_PSR;
            E_PSR:   state <= E_SYN;
            E_SYN:   state <= E_CPSR;
            E_CPSR:  state <= E_VEC;
            R_PC:    state <= R_PSR;
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    rd_reg     = '0;
    wr_reg     = '0;
    wr_fromreg = 1'b0;
    wr_fromimm = 1'b0;
    din_reg    = '0;
    case (state)
      IDLE: begin
        rd_reg     = core_rd_reg;
        wr_reg     = core_wr_reg;
        wr_fromreg = core_wr_fromreg;
        wr_fromimm = core_wr_fromimm;
        din_reg    = core_din;
      end
      E_PC:   begin rd_reg = REG_PC;   wr_reg = REG_ELR;  wr_fromreg = 1'b1; end
      E_PSR:  begin rd_reg = REG_CPSR; wr_reg = spsr_id;  wr_fromreg = 1'b1; end
      E_SYN:  begin wr_reg = REG_ESR;  wr_fromimm = 1'b1; din_reg = syn_q; end
      E_CPSR: begin wr_reg = REG_CPSR; wr_fromimm = 1'b1; din_reg = {52'b0, cpsr_q}; end
      E_VEC: begin
        rd_reg     = vec_irq_q ? REG_IVP : REG_EVP;
        wr_reg     = REG_PC;
        wr_fromreg = 1'b1;
      end
      R_PC:   begin rd_reg = REG_ELR;  wr_reg = REG_PC;   wr_fromreg = 1'b1; end
      R_PSR:  begin rd_reg = spsr_id;  wr_reg = REG_CPSR; wr_fromreg = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl: drives at the falling edge, checks 1ns later.
module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  core_rd_reg, core_wr_reg;
  logic        core_wr_fromreg, core_wr_fromimm;
  logic [63:0] core_din;
  logic        exc_req, irq_req, eret_req;
  logic [63:0] exc_syndrome;
  logic [2:0]  cur_mode;
  logic [11:0] new_cpsr;
  logic [5:0]  rd_reg, wr_reg;
  logic        wr_fromreg, wr_fromimm;
  logic [63:0] din_reg;
  logic        busy, done, seq_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_seq_ctrl #(.SPSR_COUNT(6), .IRQ_SYNDROME(64'h1)) dut (
    .clk(clk), .rst(rst),
    .core_rd_reg(core_rd_reg), .core_wr_reg(core_wr_reg),
    .core_wr_fromreg(core_wr_fromreg), .core_wr_fromimm(core_wr_fromimm),
    .core_din(core_din),
    .exc_req(exc_req), .exc_syndrome(exc_syndrome), .irq_req(irq_req),
    .eret_req(eret_req), .cur_mode(cur_mode), .new_cpsr(new_cpsr),
    .rd_reg(rd_reg), .wr_reg(wr_reg), .wr_fromreg(wr_fromreg),
    .wr_fromimm(wr_fromimm), .din_reg(din_reg),
    .busy(busy), .done(done), .seq_err(seq_err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [5:0] erd, input logic [5:0] ewr,
                     input logic efr, input logic efi, input logic [63:0] edin,
                     input logic ebusy, input logic edone, input logic eerr);
    #1;
    checks++;
    assert ({rd_reg, wr_reg, wr_fromreg, wr_fromimm, din_reg, busy, done, seq_err} ===
            {erd, ewr, efr, efi, edin, ebusy, edone, eerr})
    else begin
      errors++;
      $error("FAIL %s: got rd=%0d wr=%0d fr=%b fi=%b din=%h busy=%b done=%b err=%b; want rd=%0d wr=%0d fr=%b fi=%b din=%h busy=%b done=%b err=%b",
             tag, rd_reg, wr_reg, wr_fromreg, wr_fromimm, din_reg, busy, done, seq_err,
             erd, ewr, efr, efi, edin, ebusy, edone, eerr);
    end
  endtask

  // core pass-through pattern held throughout the run
  task automatic chk_pt(input string tag, input logic edone, input logic eerr);
    chk(tag, 6'd7, 6'd5, 1'b0, 1'b1, 64'hDEAD, 1'b0, edone, eerr);
  endtask

  task automatic garble();
    exc_req  = 1'b0;
    irq_req  = 1'b0;
    eret_req = 1'b0;
    cur_mode = 3'd5;
    new_cpsr = 12'hFFF;
    exc_syndrome = 64'hBAD0_BAD0;
  endtask

  // five entry steps, starting the cycle after acceptance
  task automatic entry(input string tag, input logic [5:0] spsr, input logic [63:0] syn,
                       input logic [11:0] cpsr, input logic [5:0] vec,
                       input logic err_first, input logic irq_at_psr);
    cyc(); garble();
    chk({tag, ".pc"}, 6'd32, 6'd34, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, err_first);
    cyc(); garble(); irq_req = irq_at_psr;
    chk({tag, ".psr"}, 6'd35, spsr, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk({tag, ".syn"}, 6'd0, 6'd33, 1'b0, 1'b1, syn, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk({tag, ".cpsr"}, 6'd0, 6'd35, 1'b0, 1'b1, {52'b0, cpsr}, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk({tag, ".vec"}, vec, 6'd32, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    core_rd_reg = '0; core_wr_reg = '0; core_wr_fromreg = 1'b0;
    core_wr_fromimm = 1'b0; core_din = '0;
    exc_req = 1'b0; irq_req = 1'b0; eret_req = 1'b0;
    exc_syndrome = '0; cur_mode = '0; new_cpsr = '0;
    #1 rst = 1'b1;

    cyc();
    chk("reset", 6'd0, 6'd0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    core_rd_reg = 6'd7; core_wr_reg = 6'd5; core_wr_fromimm = 1'b1; core_din = 64'hDEAD;
    chk_pt("idle_pt", 1'b0, 1'b0);
    cyc(); chk_pt("idle_pt2", 1'b0, 1'b0);

    // exception entry, mode 2
    cyc(); exc_req = 1'b1; exc_syndrome = 64'h42; cur_mode = 3'd2; new_cpsr = 12'h3A5;
    chk_pt("exc.accept", 1'b0, 1'b0);
    entry("exc", 6'd38, 64'h42, 12'h3A5, 6'd43, 1'b0, 1'b0);
    cyc(); garble(); chk_pt("exc.done", 1'b1, 1'b0);
    cyc(); chk_pt("exc.after", 1'b0, 1'b0);

    // interrupt entry, mode 0
    cyc(); irq_req = 1'b1; cur_mode = 3'd0; new_cpsr = 12'h0C3;
    chk_pt("irq.accept", 1'b0, 1'b0);
    entry("irq", 6'd36, 64'h1, 12'h0C3, 6'd42, 1'b0, 1'b0);
    cyc(); garble(); chk_pt("irq.done", 1'b1, 1'b0);
    cyc(); chk_pt("irq.after", 1'b0, 1'b0);

    // eret, mode 4
    cyc(); eret_req = 1'b1; cur_mode = 3'd4;
    chk_pt("eret.accept", 1'b0, 1'b0);
    cyc(); garble();
    chk("eret.pc", 6'd34, 6'd32, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk("eret.psr", 6'd40, 6'd35, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); chk_pt("eret.done", 1'b1, 1'b0);
    cyc(); chk_pt("eret.after", 1'b0, 1'b0);

    // irq arriving in entry cycle 2 runs right after the exception
    cyc(); exc_req = 1'b1; exc_syndrome = 64'h55; cur_mode = 3'd3; new_cpsr = 12'h111;
    chk_pt("col.accept", 1'b0, 1'b0);
    entry("col.exc", 6'd39, 64'h55, 12'h111, 6'd43, 1'b0, 1'b1);
    cyc(); garble(); cur_mode = 3'd1; new_cpsr = 12'h007;
    chk_pt("col.done", 1'b1, 1'b0);
    entry("col.irq", 6'd37, 64'h1, 12'h007, 6'd42, 1'b0, 1'b0);
    cyc(); garble(); chk_pt("col.irqdone", 1'b1, 1'b0);
    cyc(); chk_pt("col.after", 1'b0, 1'b0);

    // exception request during eret is dropped
    cyc(); eret_req = 1'b1; cur_mode = 3'd3;
    chk_pt("drop.accept", 1'b0, 1'b0);
    cyc(); garble(); exc_req = 1'b1; cur_mode = 3'd0;
    chk("drop.pc", 6'd34, 6'd32, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk("drop.psr", 6'd39, 6'd35, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    cyc(); chk_pt("drop.done", 1'b1, 1'b0);
    cyc(); chk_pt("drop.idle1", 1'b0, 1'b0);
    cyc(); chk_pt("drop.idle2", 1'b0, 1'b0);

    // exception and eret together: exception wins, eret flagged
    cyc(); exc_req = 1'b1; eret_req = 1'b1; exc_syndrome = 64'h99;
    cur_mode = 3'd1; new_cpsr = 12'h222;
    chk_pt("both.accept", 1'b0, 1'b0);
    entry("both", 6'd37, 64'h99, 12'h222, 6'd43, 1'b1, 1'b0);
    cyc(); garble(); chk_pt("both.done", 1'b1, 1'b0);
    cyc(); chk_pt("both.after", 1'b0, 1'b0);

    // bad modes rejected; rejected irq must not stay pending
    cyc(); exc_req = 1'b1; cur_mode = 3'd6;
    chk_pt("badexc.req", 1'b0, 1'b0);
    cyc(); exc_req = 1'b0; cur_mode = 3'd0;
    chk_pt("badexc.err", 1'b0, 1'b1);
    cyc(); irq_req = 1'b1; cur_mode = 3'd7;
    chk_pt("badirq.req", 1'b0, 1'b0);
    cyc(); irq_req = 1'b0; cur_mode = 3'd0;
    chk_pt("badirq.err", 1'b0, 1'b1);
    cyc(); chk_pt("badirq.nopend", 1'b0, 1'b0);

    // asynchronous reset in E_SYN aborts the sequence
    cyc(); exc_req = 1'b1; exc_syndrome = 64'h77; cur_mode = 3'd0; new_cpsr = 12'h333;
    chk_pt("rst.accept", 1'b0, 1'b0);
    cyc(); garble();
    chk("rst.pc", 6'd32, 6'd34, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); garble();
    chk("rst.psr", 6'd35, 6'd36, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(); garble(); cur_mode = 3'd0;
    chk("rst.syn", 6'd0, 6'd33, 1'b0, 1'b1, 64'h77, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    chk_pt("rst.async", 1'b0, 1'b0);
    cyc(); rst = 1'b0;
    chk_pt("rst.held", 1'b0, 1'b0);
    cyc(); chk_pt("rst.nodone1", 1'b0, 1'b0);
    cyc(); chk_pt("rst.nodone2", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
